ask_modulator: RTL
==================

Name: ask_modulator

Overview:
- Transmit-side counterpart of the ASK demodulator. Takes parallel words over a valid/ready handshake and serialises each one into a framed bit stream.
- Each bit is on-off keyed onto a square-wave carrier that is derived from the system clock.
- Drives the board-level modulated output and its differential complement, feeding the same link that the demodulator top receives.

Parameters:
- WORD_W, 8, data bits per word.
- CARRIER_DIV, 5, clocks per carrier half-period (≥1).
- CYCLES_PER_BIT, 8, full carrier periods per keyed bit (≥1).
- Derived: BIT_CLKS = 2*CARRIER_DIV*CYCLES_PER_BIT.

Ports:
- MAX10_CLK1_50  in  1  system clock, single domain.
- rst_n  in  1  asynchronous, active-low reset.
- word_in  in  WORD_W  word to transmit, sampled on handshake.
- word_valid  in  1  word_in is valid.
- word_ready  out  1  modulator can accept a word.
- ask_out  out  1  keyed carrier.
- ask_out_n  out  1  inverted carrier while keyed on, 0 while keyed off.
- tx_bit  out  1  frame bit currently being keyed.
- busy  out  1  a frame is in progress.
- word_done  out  1  one-cycle pulse on the last clock of a frame.

Behaviour:
- Reset, asynchronous: state=IDLE, shift register and counters=0. Outputs ask_out, ask_out_n, tx_bit, busy, word_done = 0. word_ready = 1, since it is decoded from IDLE.
- Frame format, bits in order:
  - start bit = 1 (carrier on);
  - WORD_W data bits, MSB first;
  - [parity bit, see optional feature];
  - stop bit = 0 (carrier off).
- Handshake:
  - word_ready = (state==IDLE).
  - Accept on word_valid & word_ready; word_in is latched that cycle.
  - word_valid without word_ready is ignored; the source must hold its word.
- State machine:
  - IDLE → START on accept.
  - START → DATA at bit_end.
  - DATA → DATA at bit_end while bits remain; after bit index WORD_W-1 it goes to STOP, or PARITY when enabled.
  - PARITY → STOP at bit_end.
  - STOP → IDLE at bit_end.
- Minimum IDLE dwell is 1 cycle, so back-to-back frames have exactly one idle clock between them.
- Carrier generation:
  - div_cnt counts 0..CARRIER_DIV-1.
  - At each wrap the carrier phase toggles and hp_cnt counts 0..2*CYCLES_PER_BIT-1.
  - bit_end = div_cnt==CARRIER_DIV-1 and hp_cnt==2*CYCLES_PER_BIT-1.
  - Both counters and the phase (to high) are reset at accept and at every bit_end, so each bit starts with a carrier high half-period and lasts exactly BIT_CLKS clocks.
- Outputs:
  - All outputs are registered.
  - ask_out = phase & tx_bit; ask_out_n = ~phase & tx_bit.
  - First carrier high appears the cycle after accept (latency 1).
- busy = 1 from the cycle after accept through the last STOP clock.
- word_done asserts on the last STOP clock; word_ready returns high on the next clock.
- Frame length is (WORD_W+2)*BIT_CLKS clocks, plus BIT_CLKS when parity is enabled.
- Reset mid-frame aborts immediately. Outputs go to their reset values, with no partial stop bit and no word_done.
- word_in changing after accept has no effect.

Optional Feature:
- Macro ASK_PARITY_EN.
  - Defined: a PARITY state is inserted after the data bits, keying even parity of the latched word (XOR reduction). Frame becomes WORD_W+3 bits.
  - Undefined: no PARITY state and no parity logic; frame is WORD_W+2 bits.

Decomposition:
- Package ask_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - START_LEVEL=1 and STOP_LEVEL=0 constants;
  - bit_clks(div, cpb) constant function.
  - The demodulator side reuses the same package.
- Sub-module ask_carrier_gen:
  - holds div_cnt, hp_cnt and phase;
  - inputs: restart strobe; outputs: phase and bit_end.
- The top FSM and shift register remain in ask_modulator.

Test Plan (bench parameters CARRIER_DIV=1, CYCLES_PER_BIT=2, so BIT_CLKS=4):
- Reset: assert rst_n=0 mid-clock → outputs immediately 0 and word_ready=1. Release → ask_out stays 0 for 20 idle clocks.
- Send 8'hA5, no parity → tx_bit sequence 1,1,0,1,0,0,1,0,1,0, each held 4 clocks. ask_out reads 1010 during 1-bits and 0000 during 0-bits. word_done on clock 40 after accept; word_ready=1 on clock 41.
- Back-to-back: word_valid held high with 8'hFF then 8'h00 → second accept exactly 1 clock after the first word_done. Second frame tx_bit = 1, eight 0s, 0.
- Reset mid-frame: rst_n=0 at clock 13 of an 8'hA5 frame → ask_out, busy, tx_bit = 0 at once, no word_done. A new word is accepted cleanly after release.
- ASK_PARITY_EN defined, send 8'h01 → parity bit 1 keyed in bit slot 9, frame 44 clocks. Send 8'hA5 → parity 0, frame 44 clocks.
- ask_out_n check → always the complement of ask_out while tx_bit=1, always 0 while tx_bit=0.

Source files
------------

// File: rtl/ask_pkg.sv
// Shared definitions for the ASK modulator and demodulator: FSM states, frame levels
// and bit-timing helper.
package ask_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  localparam logic START_LEVEL = 1'b1;
  localparam logic STOP_LEVEL  = 1'b0;

  // Clocks per keyed bit: two half-periods of div clocks, cpb carrier periods.
  function automatic int unsigned bit_clks(input int unsigned div, input int unsigned cpb);
    return 2 * div * cpb;
  endfunction

endpackage

// File: rtl/ask_carrier_gen.sv
// Square-wave carrier and bit-slot timer. A restart strobe realigns the carrier to the
// start of a high half-period and begins a new bit slot.
module ask_carrier_gen #(
  parameter int unsigned CARRIER_DIV    = 5,
  parameter int unsigned CYCLES_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic phase_nxt,
  output logic bit_end,
  output logic bit_end_nxt
);

  localparam int unsigned HalfPeriods = 2 * CYCLES_PER_BIT;
  localparam int unsigned DivW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
  localparam int unsigned HpW  = $clog2(HalfPeriods);

  logic [DivW-1:0] div_q, div_d;
  logic [HpW-1:0]  hp_q, hp_d;
  logic            phase_q, phase_d;
  logic            bit_end_q;

  always_comb begin
    div_d   = div_q;
    hp_d    = hp_q;
    phase_d = phase_q;
    if (restart) begin
      div_d   = '0;
      hp_d    = '0;
      phase_d = 1'b1;
    end else if (div_q == DivW'(CARRIER_DIV - 1)) begin
      div_d   = '0;
      phase_d = ~phase_q;
      hp_d    = (hp_q == HpW'(HalfPeriods - 1)) ? '0 : hp_q + HpW'(1);
    end else begin
      div_d = div_q + DivW'(1);
    end
  end

  // Look-ahead lets the top register word_done on the final clock of a slot.
  assign bit_end_nxt = (div_d == DivW'(CARRIER_DIV - 1)) && (hp_d == HpW'(HalfPeriods - 1));
  assign phase_nxt   = phase_d;
  assign bit_end     = bit_end_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      hp_q      <= '0;
      phase_q   <= 1'b0;
      bit_end_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      hp_q      <= hp_d;
      phase_q   <= phase_d;
      bit_end_q <= bit_end_nxt;
    end
  end

endmodule

// File: rtl/ask_modulator.sv
// ASK transmitter: frames each accepted word (start, data MSB first, stop) and on-off keys
// it onto the carrier. Define ASK_PARITY_EN to insert an even-parity bit before stop.
module ask_modulator
  import ask_pkg::*;
#(
  parameter int unsigned WORD_W         = 8,
  parameter int unsigned CARRIER_DIV    = 5,
  parameter int unsigned CYCLES_PER_BIT = 8
) (
  input  logic              MAX10_CLK1_50,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ask_out,
  output logic              ask_out_n,
  output logic              tx_bit,
  output logic              busy,
  output logic              word_done
);

  localparam int unsigned IdxW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              tx_q, tx_d;
  logic              ask_q, ask_n_q, busy_q, done_q;
`ifdef ASK_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic accept, restart, phase_nxt, bit_end, bit_end_nxt;

  assign word_ready = (state_q == StIdle);
  assign accept     = word_valid & word_ready;
  assign restart    = accept | ((state_q != StIdle) & bit_end);

  ask_carrier_gen #(
    .CARRIER_DIV    (CARRIER_DIV),
    .CYCLES_PER_BIT (CYCLES_PER_BIT)
  ) u_carrier (
    .clk         (MAX10_CLK1_50),
    .rst_n       (rst_n),
    .restart     (restart),
    .phase_nxt   (phase_nxt),
    .bit_end     (bit_end),
    .bit_end_nxt (bit_end_nxt)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    tx_d     = tx_q;
`ifdef ASK_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d  = StStart;
          shreg_d  = word_in;
          idx_d    = '0;
          tx_d     = START_LEVEL;
`ifdef ASK_PARITY_EN
          parity_d = ^word_in;
`endif
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          tx_d    = shreg_q[WORD_W-1];
          shreg_d = shreg_q << 1;
        end
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == IdxW'(WORD_W - 1)) begin
`ifdef ASK_PARITY_EN
            state_d = StParity;
            tx_d    = parity_q;
`else
            state_d = StStop;
            tx_d    = STOP_LEVEL;
`endif
          end else begin
            idx_d   = idx_q + IdxW'(1);
            tx_d    = shreg_q[WORD_W-1];
            shreg_d = shreg_q << 1;
          end
        end
      end
`ifdef ASK_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          tx_d    = STOP_LEVEL;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          tx_d    = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      idx_q    <= '0;
      tx_q     <= 1'b0;
      ask_q    <= 1'b0;
      ask_n_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ASK_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
      ask_q    <= phase_nxt & tx_d;
      ask_n_q  <= ~phase_nxt & tx_d;
      busy_q   <= (state_d != StIdle);
      done_q   <= (state_d == StStop) & bit_end_nxt;
`ifdef ASK_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx_bit    = tx_q;
  assign ask_out   = ask_q;
  assign ask_out_n = ask_n_q;
  assign busy      = busy_q;
  assign word_done = done_q;

endmodule
